parc_core_reorder_buffer_n: RTL and testbench

Parametrised in-order-commit reorder buffer for the out-of-order PARC core. It allocates entries in program order at dispatch and accepts out-of-order completion fills from several writeback ports. It retires one completed entry per cycle from the head, and squashes all entries younger than a given slot on a branch-mispredict flush. It sits between the dispatch/rename stage and the architectural register-file write port.

---
 rtl/parc_core_rob_pkg.sv | 24 ++
 rtl/parc_core_rob_flush_mask.sv | 29 ++
 rtl/parc_core_reorder_buffer_n.sv | 107 ++++++++++
 tb/tb_parc_core_reorder_buffer_n.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parc_core_rob_pkg.sv
// Shared definitions for the PARC reorder buffer: entry field layout and
// the age comparison used when squashing on a mispredict.
package parc_core_rob_pkg;

  localparam int ROB_VALID   = 0;
  localparam int ROB_PENDING = 1;
  localparam int ROB_WEN     = 2;
  localparam int ROB_PREG    = 3;

  function automatic int rob_entry_w(input int preg_w);
    return ROB_PREG + preg_w;
  endfunction

  // Age is the forward distance from head, so wrap-around needs no special case.
  function automatic logic rob_younger(input int unsigned a, input int unsigned b,
                                       input int unsigned head, input int unsigned depth);
    int unsigned age_a;
    int unsigned age_b;
    age_a = (a - head) & (depth - 1);
    age_b = (b - head) & (depth - 1);
    return age_a > age_b;
  endfunction

endpackage

// File: rtl/parc_core_rob_flush_mask.sv
// Combinational squash mask: marks every occupied slot strictly younger
// than flush_slot, with age measured from head.
module parc_core_rob_flush_mask
  import parc_core_rob_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int SLOT_W = $clog2(DEPTH)
) (
  input  logic [SLOT_W:0]   head,
  input  logic [SLOT_W:0]   tail,
  input  logic [SLOT_W-1:0] flush_slot,
  output logic [DEPTH-1:0]  mask
);

  logic [SLOT_W:0] count;
  logic [SLOT_W:0] age;

  always_comb begin
    count = tail - head;
    age   = '0;
    mask  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age     = {1'b0, SLOT_W'(i) - head[SLOT_W-1:0]};
      mask[i] = (age < count) &&
                rob_younger(i, 32'(flush_slot), 32'(head[SLOT_W-1:0]), DEPTH);
    end
  end

endmodule

// File: rtl/parc_core_reorder_buffer_n.sv
// In-order-commit reorder buffer: program-order allocation, out-of-order
// fills from NUM_FILL writeback ports, single head retirement, flush squash.
module parc_core_reorder_buffer_n
  import parc_core_rob_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PREG_W   = 5,
  parameter int NUM_FILL = 2,
  localparam int SLOT_W  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rob_alloc_req_val,
  output logic                       rob_alloc_req_rdy,
  input  logic [PREG_W-1:0]          rob_alloc_req_preg,
  input  logic                       rob_alloc_req_wen,
  output logic [SLOT_W-1:0]          rob_alloc_resp_slot,
  input  logic [NUM_FILL-1:0]        rob_fill_val,
  input  logic [NUM_FILL*SLOT_W-1:0] rob_fill_slot,
  input  logic                       rob_flush_val,
  input  logic [SLOT_W-1:0]          rob_flush_slot,
  output logic                       rob_commit_val,
  output logic                       rob_commit_wen,
  output logic [SLOT_W-1:0]          rob_commit_slot,
  output logic [PREG_W-1:0]          rob_commit_rf_waddr,
  output logic [SLOT_W:0]            rob_count,
  output logic                       rob_empty
);

  localparam int ENTRY_W = rob_entry_w(PREG_W);
  localparam logic [SLOT_W:0] PTR_ONE = 1;
  localparam logic [SLOT_W:0] PTR_DEPTH = DEPTH[SLOT_W:0];

  logic [ENTRY_W-1:0] ent_q [DEPTH];
  logic [SLOT_W:0]    head_q, tail_q, count, flush_tail;
  logic [SLOT_W-1:0]  head_idx, tail_idx;
  logic [ENTRY_W-1:0] head_ent, alloc_ent;
  logic [DEPTH-1:0]   squash;
  logic               full, alloc_fire, commit_fire, flush_fire;

  assign head_idx    = head_q[SLOT_W-1:0];
  assign tail_idx    = tail_q[SLOT_W-1:0];
  assign count       = tail_q - head_q;
  assign full        = (count == PTR_DEPTH);
  assign head_ent    = ent_q[head_idx];
  assign flush_fire  = rob_flush_val && ent_q[rob_flush_slot][ROB_VALID];
  assign commit_fire = head_ent[ROB_VALID] && !head_ent[ROB_PENDING];
  // Rebuilding tail from head keeps the wrap bit consistent with head.
  assign flush_tail  = head_q + {1'b0, rob_flush_slot - head_idx} + PTR_ONE;

  // Alloc handshake: an entry is taken only on a cycle where val and rdy are
  // both high; rdy never depends on val and drops whenever a flush is requested.
  assign rob_alloc_req_rdy   = !full && !rob_flush_val;
  assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;
  assign rob_alloc_resp_slot = tail_idx;

  assign rob_commit_val      = commit_fire;
  assign rob_commit_wen      = commit_fire && head_ent[ROB_WEN];
  assign rob_commit_slot     = head_idx;
  assign rob_commit_rf_waddr = head_ent[ROB_PREG +: PREG_W];
  assign rob_count           = count;
  assign rob_empty           = (count == '0);

  always_comb begin
    alloc_ent                    = '0;
    alloc_ent[ROB_VALID]         = 1'b1;
    alloc_ent[ROB_PENDING]       = 1'b1;
    alloc_ent[ROB_WEN]           = rob_alloc_req_wen;
    alloc_ent[ROB_PREG +: PREG_W] = rob_alloc_req_preg;
  end

  parc_core_rob_flush_mask #(.DEPTH(DEPTH)) u_flush_mask (
    .head       (head_q),
    .tail       (tail_q),
    .flush_slot (rob_flush_slot),
    .mask       (squash)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_FILL; k++) begin
        if (rob_fill_val[k] && ent_q[rob_fill_slot[k*SLOT_W +: SLOT_W]][ROB_VALID])
          ent_q[rob_fill_slot[k*SLOT_W +: SLOT_W]][ROB_PENDING] <= 1'b0;
      end
      // Later writes override fills, so a squashed slot stays invalid.
      if (flush_fire) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (squash[i]) ent_q[i] <= '0;
        end
        tail_q <= flush_tail;
      end
      if (commit_fire) begin
        ent_q[head_idx] <= '0;
        head_q          <= head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        ent_q[tail_idx] <= alloc_ent;
        tail_q          <= tail_q + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_parc_core_reorder_buffer_n.sv
// Bench for parc_core_reorder_buffer_n: directed scenarios plus random traffic
// checked against a program-order queue model of the buffer.
module tb_parc_core_reorder_buffer_n;

  localparam int DEPTH    = 16;
  localparam int PREG_W   = 5;
  localparam int NUM_FILL = 2;
  localparam int SLOT_W   = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       rob_alloc_req_val;
  logic                       rob_alloc_req_rdy;
  logic [PREG_W-1:0]          rob_alloc_req_preg;
  logic                       rob_alloc_req_wen;
  logic [SLOT_W-1:0]          rob_alloc_resp_slot;
  logic [NUM_FILL-1:0]        rob_fill_val;
  logic [NUM_FILL*SLOT_W-1:0] rob_fill_slot;
  logic                       rob_flush_val;
  logic [SLOT_W-1:0]          rob_flush_slot;
  logic                       rob_commit_val;
  logic                       rob_commit_wen;
  logic [SLOT_W-1:0]          rob_commit_slot;
  logic [PREG_W-1:0]          rob_commit_rf_waddr;
  logic [SLOT_W:0]            rob_count;
  logic                       rob_empty;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  parc_core_reorder_buffer_n #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NUM_FILL(NUM_FILL)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rob_alloc_req_val   (rob_alloc_req_val),
    .rob_alloc_req_rdy   (rob_alloc_req_rdy),
    .rob_alloc_req_preg  (rob_alloc_req_preg),
    .rob_alloc_req_wen   (rob_alloc_req_wen),
    .rob_alloc_resp_slot (rob_alloc_resp_slot),
    .rob_fill_val        (rob_fill_val),
    .rob_fill_slot       (rob_fill_slot),
    .rob_flush_val       (rob_flush_val),
    .rob_flush_slot      (rob_flush_slot),
    .rob_commit_val      (rob_commit_val),
    .rob_commit_wen      (rob_commit_wen),
    .rob_commit_slot     (rob_commit_slot),
    .rob_commit_rf_waddr (rob_commit_rf_waddr),
    .rob_count           (rob_count),
    .rob_empty           (rob_empty)
  );

  // ---------------- scoreboard / reference model ----------------
  // Occupied entries in program order; the front is the oldest instruction.
  typedef struct {
    int slot;
    int preg;
    bit wen;
    bit pending;
  } ent_t;

  ent_t model_q[$];
  int   model_head;
  int   n_checks;
  int   n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_head = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rdy"},       rob_alloc_req_rdy, 1);
    check_eq({tag, "_resp"},      rob_alloc_resp_slot, 0);
    check_eq({tag, "_cval"},      rob_commit_val, 0);
    check_eq({tag, "_cwen"},      rob_commit_wen, 0);
    check_eq({tag, "_cslot"},     rob_commit_slot, 0);
    check_eq({tag, "_waddr"},     rob_commit_rf_waddr, 0);
    check_eq({tag, "_count"},     rob_count, 0);
    check_eq({tag, "_empty"},     rob_empty, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rob_alloc_req_val  = 1'b0;
    rob_alloc_req_preg = '0;
    rob_alloc_req_wen  = 1'b0;
    rob_fill_val       = '0;
    rob_fill_slot      = '0;
    rob_flush_val      = 1'b0;
    rob_flush_slot     = '0;
  endtask

  task automatic set_fill(input int port, input int slot);
    rob_fill_val[port]                    = 1'b1;
    rob_fill_slot[port*SLOT_W +: SLOT_W]  = SLOT_W'(slot);
  endtask

  // Called just after a falling edge with inputs already driven: checks the
  // combinational outputs against the model, then advances the model across
  // the rising edge using the same inputs.
  task automatic step();
    bit fire;
    bit accept;
    int tail_slot;
    int fidx;
    #1;
    fire      = (model_q.size() > 0) && !model_q[0].pending;
    tail_slot = (model_head + model_q.size()) % DEPTH;
    accept    = rob_alloc_req_val && (model_q.size() < DEPTH) && !rob_flush_val;
    check_eq("commit_val", rob_commit_val, fire);
    check_eq("commit_wen", rob_commit_wen, fire ? model_q[0].wen : 1'b0);
    if (fire) check_eq("rf_waddr", rob_commit_rf_waddr, model_q[0].preg);
    check_eq("commit_slot", rob_commit_slot, model_head);
    check_eq("count", rob_count, model_q.size());
    check_eq("empty", rob_empty, model_q.size() == 0);
    check_eq("rdy", rob_alloc_req_rdy, (model_q.size() < DEPTH) && !rob_flush_val);
    check_eq("resp_slot", rob_alloc_resp_slot, tail_slot);
    @(posedge clk);
    for (int k = 0; k < NUM_FILL; k++) begin
      if (rob_fill_val[k]) begin
        foreach (model_q[j])
          if (model_q[j].slot == int'(rob_fill_slot[k*SLOT_W +: SLOT_W])) model_q[j].pending = 1'b0;
      end
    end
    if (rob_flush_val) begin
      fidx = -1;
      foreach (model_q[j]) if (model_q[j].slot == int'(rob_flush_slot)) fidx = j;
      if (fidx >= 0) model_q = model_q[0:fidx];
    end
    if (fire) begin
      void'(model_q.pop_front());
      model_head = (model_head + 1) % DEPTH;
    end
    if (accept)
      model_q.push_back('{slot: tail_slot, preg: int'(rob_alloc_req_preg),
                          wen: rob_alloc_req_wen, pending: 1'b1});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Fill the two oldest entries each cycle until the buffer is empty.
  task automatic drain();
    for (int c = 0; c < 4 * DEPTH && model_q.size() > 0; c++) begin
      clear_inputs();
      set_fill(0, model_q[0].slot);
      if (model_q.size() > 1) set_fill(1, model_q[1].slot);
      step();
    end
    clear_inputs();
    step();
    check_eq("drain_empty", rob_empty, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Three allocations, no fills.
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      rob_alloc_req_val  = 1'b1;
      rob_alloc_req_preg = PREG_W'(5 + i);
      rob_alloc_req_wen  = 1'b1;
      #1;
      check_eq("alloc_slot", rob_alloc_resp_slot, i);
      step();
    end
    clear_inputs();
    #1;
    check_eq("three_count", rob_count, 3);
    check_eq("three_no_commit", rob_commit_val, 0);

    // Out-of-order completion: slot 2 then slot 0 on port 1.
    set_fill(0, 2);
    step();
    clear_inputs();
    set_fill(1, 0);
    step();
    clear_inputs();
    #1;
    check_eq("ooo_commit0_val", rob_commit_val, 1);
    check_eq("ooo_commit0_slot", rob_commit_slot, 0);
    check_eq("ooo_commit0_waddr", rob_commit_rf_waddr, 5);
    step();
    #1;
    check_eq("ooo_slot1_blocks", rob_commit_val, 0);
    set_fill(0, 1);
    step();
    clear_inputs();
    #1;
    check_eq("ooo_commit1_slot", rob_commit_slot, 1);
    step();
    #1;
    check_eq("ooo_commit2_slot", rob_commit_slot, 2);
    check_eq("ooo_commit2_val", rob_commit_val, 1);
    step();
    step();

    // Fill all sixteen entries, then retire one while alloc is held.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      clear_inputs();
      rob_alloc_req_val  = 1'b1;
      rob_alloc_req_preg = PREG_W'($urandom_range(0, 31));
      rob_alloc_req_wen  = 1'($urandom_range(0, 1));
      step();
    end
    #1;
    check_eq("full_rdy", rob_alloc_req_rdy, 0);
    check_eq("full_count", rob_count, DEPTH);
    set_fill(0, 0);
    step();
    rob_fill_val = '0;
    #1;
    check_eq("full_commit_val", rob_commit_val, 1);
    check_eq("full_commit_rdy", rob_alloc_req_rdy, 0);
    step();
    #1;
    check_eq("wrap_rdy", rob_alloc_req_rdy, 1);
    check_eq("wrap_slot", rob_alloc_resp_slot, 0);
    step();
    drain();

    // Flush with head at 14 and entries 14,15,0,1,2 occupied.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      rob_alloc_req_val  = 1'b1;
      rob_alloc_req_preg = PREG_W'(i);
      rob_alloc_req_wen  = 1'b1;
      step();
    end
    drain();
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      rob_alloc_req_val  = 1'b1;
      rob_alloc_req_preg = PREG_W'(20 + i);
      rob_alloc_req_wen  = 1'b1;
      step();
    end
    rob_flush_val  = 1'b1;
    rob_flush_slot = 4'd15;
    set_fill(0, 1);
    #1;
    check_eq("flush_alloc_refused", rob_alloc_req_rdy, 0);
    step();
    clear_inputs();
    #1;
    check_eq("flush_count", rob_count, 2);
    check_eq("flush_tail", rob_alloc_resp_slot, 0);
    check_eq("flush_head", rob_commit_slot, 14);
    step();
    drain();

    // Both fill ports on the same slot, entry without a register write.
    clear_inputs();
    rob_alloc_req_val  = 1'b1;
    rob_alloc_req_preg = 5'd9;
    rob_alloc_req_wen  = 1'b0;
    step();
    clear_inputs();
    rob_alloc_req_val  = 1'b1;
    rob_alloc_req_preg = 5'd10;
    rob_alloc_req_wen  = 1'b1;
    set_fill(0, model_q[0].slot);
    set_fill(1, model_q[0].slot);
    step();
    clear_inputs();
    #1;
    check_eq("dual_fill_val", rob_commit_val, 1);
    check_eq("dual_fill_wen", rob_commit_wen, 0);
    check_eq("dual_fill_waddr", rob_commit_rf_waddr, 9);

    // Reset mid-stream: outputs drop back within the cycle.
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the queue model.
    for (int c = 0; c < 1500; c++) begin
      clear_inputs();
      rob_alloc_req_val  = ($urandom_range(0, 9) < 7);
      rob_alloc_req_preg = PREG_W'($urandom_range(0, 31));
      rob_alloc_req_wen  = 1'($urandom_range(0, 1));
      for (int k = 0; k < NUM_FILL; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
            set_fill(k, model_q[$urandom_range(0, model_q.size() - 1)].slot);
          else
            set_fill(k, $urandom_range(0, DEPTH - 1));
        end
      end
      if ($urandom_range(0, 24) == 0) begin
        rob_flush_val = 1'b1;
        if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
          rob_flush_slot = SLOT_W'(model_q[$urandom_range(0, model_q.size() - 1)].slot);
        else
          rob_flush_slot = SLOT_W'($urandom_range(0, DEPTH - 1));
      end
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
